// File: rtl/seg7_msg_scroller.sv
`default_nettype none
// ============================================================================
// seg7_msg_scroller
// Scrolls a display index through a writable 7-segment message buffer.
// Revision: 1.0
// ============================================================================
module seg7_msg_scroller #(
    parameter int DIV_W   = 24,
    parameter int MSG_LEN = 16,
    parameter int IDX_W   = 4,
    parameter int DEF_DIV = 10_000_000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         mode,
    input  logic               step,
    input  logic               step_dir,
    input  logic               cfg_we,
    input  logic [DIV_W-1:0]   tick_div,
    input  logic [IDX_W:0]     msg_len,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_addr,
    input  logic [6:0]         wr_data,
    output logic [6:0]         seg_out,
    output logic [IDX_W-1:0]   idx_out,
    output logic               wrap,
    output logic [7:0]         dbg_cnt
);

    localparam int               DEPTH     = 2**IDX_W;
    localparam logic [1:0]       MODE_FWD  = 2'b01;
    localparam logic [1:0]       MODE_REV  = 2'b10;
    localparam logic [1:0]       MODE_STEP = 2'b11;
    localparam logic [IDX_W:0]   LEN_MAX   = (IDX_W+1)'(MSG_LEN);
    localparam logic [IDX_W:0]   LEN_MIN   = (IDX_W+1)'(1);
    localparam logic [DIV_W-1:0] DIV_RESET = DIV_W'(DEF_DIV);

    logic [DIV_W-1:0] count_q, count_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [IDX_W:0]   len_q, len_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [6:0]       seg_q, seg_d;
    logic             wrap_q, wrap_d;
    logic [6:0]       mem_q [DEPTH];
    logic [6:0]       mem_d [DEPTH];

    logic             tick;
    logic             advance;
    logic             reverse;
    logic [IDX_W:0]   len_clamped;
    logic [IDX_W-1:0] last_idx;

    assign tick     = (count_q == div_q);
    // len_q may equal 2**IDX_W; the low bits wrap to 0 and the decrement wraps back.
    assign last_idx = len_q[IDX_W-1:0] - IDX_W'(1);

    always_comb begin
        len_clamped = msg_len;
        if (msg_len == '0) begin
            len_clamped = LEN_MIN;
        end else if (msg_len > LEN_MAX) begin
            len_clamped = LEN_MAX;
        end
    end

    always_comb begin
        advance = 1'b0;
        reverse = 1'b0;
        case (mode)
            MODE_FWD: begin
                advance = tick;
            end
            MODE_REV: begin
                advance = tick;
                reverse = 1'b1;
            end
            MODE_STEP: begin
                advance = step;
                reverse = step_dir;
            end
            default: begin
                advance = 1'b0;
            end
        endcase
    end

    always_comb begin
        count_d = tick ? '0 : count_q + DIV_W'(1);
        div_d   = div_q;
        len_d   = len_q;
        idx_d   = idx_q;
        wrap_d  = 1'b0;
        // A config load takes priority and swallows any coincident advance.
        if (cfg_we) begin
            div_d   = tick_div;
            count_d = '0;
            len_d   = len_clamped;
            if ({1'b0, idx_q} >= len_clamped) begin
                idx_d = '0;
            end
        end else if (advance) begin
            if (!reverse) begin
                if (idx_q == last_idx) begin
                    idx_d  = '0;
                    wrap_d = 1'b1;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end else begin
                if (idx_q == '0) begin
                    idx_d  = last_idx;
                    wrap_d = 1'b1;
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
        end
    end

    always_comb begin
        mem_d = mem_q;
        if (wr_en && ({1'b0, wr_addr} < LEN_MAX)) begin
            mem_d[wr_addr] = wr_data;
        end
        seg_d = mem_q[idx_q];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            div_q   <= DIV_RESET;
            len_q   <= LEN_MAX;
            idx_q   <= '0;
            seg_q   <= '0;
            wrap_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            div_q   <= div_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            wrap_q  <= wrap_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign seg_out = seg_q;
    assign idx_out = idx_q;
    assign wrap    = wrap_q;

    generate
        if (DIV_W >= 8) begin : g_dbg_direct
            assign dbg_cnt = count_q[7:0];
        end else begin : g_dbg_pad
            assign dbg_cnt = {{(8-DIV_W){1'b0}}, count_q};
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_seg7_msg_scroller.sv
`default_nettype none
// ============================================================================
// tb_seg7_msg_scroller
// Directed and random stimulus against an arithmetic model of the scroller.
// Revision: 1.0
// ============================================================================
module tb_seg7_msg_scroller;

    localparam int DIV_W   = 10;
    localparam int MSG_LEN = 16;
    localparam int IDX_W   = 5;
    localparam int DEF_DIV = 20;

    logic               clk = 1'b0;
    logic               reset;
    logic [1:0]         mode;
    logic               step;
    logic               step_dir;
    logic               cfg_we;
    logic [DIV_W-1:0]   tick_div;
    logic [IDX_W:0]     msg_len;
    logic               wr_en;
    logic [IDX_W-1:0]   wr_addr;
    logic [6:0]         wr_data;
    logic [6:0]         seg_out;
    logic [IDX_W-1:0]   idx_out;
    logic               wrap;
    logic [7:0]         dbg_cnt;

    always #5 clk = ~clk;

    seg7_msg_scroller #(
        .DIV_W   (DIV_W),
        .MSG_LEN (MSG_LEN),
        .IDX_W   (IDX_W),
        .DEF_DIV (DEF_DIV)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .mode     (mode),
        .step     (step),
        .step_dir (step_dir),
        .cfg_we   (cfg_we),
        .tick_div (tick_div),
        .msg_len  (msg_len),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .seg_out  (seg_out),
        .idx_out  (idx_out),
        .wrap     (wrap),
        .dbg_cnt  (dbg_cnt)
    );

    int m_cnt, m_div, m_len, m_idx, m_seg, m_wrap;
    int m_buf [MSG_LEN];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: applies one clock edge using the inputs seen at that edge.
    task automatic model_edge();
        int  tick;
        int  nseg;
        int  nl;
        bit  adv;
        bit  rev;
        if (reset) begin
            m_cnt = 0; m_div = DEF_DIV; m_len = MSG_LEN;
            m_idx = 0; m_seg = 0; m_wrap = 0;
            for (int i = 0; i < MSG_LEN; i++) m_buf[i] = 0;
        end else begin
            tick   = (m_cnt == m_div);
            nseg   = m_buf[m_idx];
            m_wrap = 0;
            if (cfg_we) begin
                m_div = tick_div;
                m_cnt = 0;
                nl = msg_len;
                if (nl < 1) nl = 1;
                if (nl > MSG_LEN) nl = MSG_LEN;
                m_len = nl;
                if (m_idx >= m_len) m_idx = 0;
            end else begin
                adv = ((mode == 2'b01 || mode == 2'b10) && tick != 0) || (mode == 2'b11 && step);
                rev = (mode == 2'b10) || (mode == 2'b11 && step_dir);
                m_cnt = (tick != 0) ? 0 : m_cnt + 1;
                if (adv) begin
                    if (!rev) begin
                        m_wrap = (m_idx + 1 == m_len);
                        m_idx  = (m_idx + 1) % m_len;
                    end else begin
                        m_wrap = (m_idx == 0);
                        m_idx  = (m_idx + m_len - 1) % m_len;
                    end
                end
            end
            if (wr_en && wr_addr < MSG_LEN) m_buf[wr_addr] = wr_data;
            m_seg = nseg;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check("seg_out", seg_out, m_seg);
        check("idx_out", idx_out, m_idx);
        check("wrap",    wrap,    m_wrap);
        check("dbg_cnt", dbg_cnt, m_cnt % 256);
    endtask

    task automatic idle();
        reset = 1'b0; step = 1'b0; cfg_we = 1'b0; wr_en = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_cfg(input int div, input int len);
        cfg_we = 1'b1; tick_div = DIV_W'(div); msg_len = (IDX_W+1)'(len);
        cycle();
        cfg_we = 1'b0;
    endtask

    task automatic do_step(input bit dir);
        step = 1'b1; step_dir = dir;
        cycle();
        step = 1'b0;
    endtask

    task automatic wait_idx(input int target, input int budget);
        int k = 0;
        while (m_idx != target && k < budget) begin
            cycle();
            k++;
        end
        check("wait_idx_reached", idx_out, target);
    endtask

    initial begin
        int k;
        reset = 1'b1; mode = 2'b00; step = 1'b0; step_dir = 1'b0; cfg_we = 1'b0;
        tick_div = '0; msg_len = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        run(2);
        check("rst_idx", idx_out, 0);
        check("rst_seg", seg_out, 0);
        check("rst_wrap", wrap, 0);
        check("rst_cnt", dbg_cnt, 0);
        idle();

        // Load four entries, then auto-forward over a 4-entry message.
        wr_en = 1'b1;
        wr_addr = 5'd0; wr_data = 7'h3E; cycle();
        wr_addr = 5'd1; wr_data = 7'h77; cycle();
        wr_addr = 5'd2; wr_data = 7'h7C; cycle();
        wr_addr = 5'd3; wr_data = 7'h39; cycle();
        wr_en = 1'b0;
        mode = 2'b01;
        do_cfg(3, 4);
        check("cfg_cnt0", dbg_cnt, 0);
        run(4);
        check("fwd_first_idx", idx_out, 1);
        check("fwd_seg_idx0", seg_out, 7'h3E);
        run(1);
        check("fwd_seg_idx1", seg_out, 7'h77);
        run(16);

        // Auto-reverse starting from index 0.
        wait_idx(0, 20);
        mode = 2'b10;
        run(1);
        wait_idx(3, 10);
        check("rev_wrap", wrap, 1);
        run(1);
        check("rev_seg_idx3", seg_out, 7'h39);
        run(16);

        // Manual stepping with a tick every cycle.
        wait_idx(0, 20);
        mode = 2'b11;
        do_cfg(0, 4);
        run(2);
        check("man_hold", idx_out, 0);
        do_step(1'b0);
        check("man_step1", idx_out, 1);
        run(3);
        do_step(1'b0);
        check("man_step2", idx_out, 2);
        run(2);
        do_step(1'b1);
        check("man_step3", idx_out, 1);
        run(2);

        // Shrink the message while at index 3; coincident step must be ignored.
        do_step(1'b0);
        do_step(1'b0);
        check("at_idx3", idx_out, 3);
        step = 1'b1; step_dir = 1'b0;
        do_cfg(0, 2);
        step = 1'b0;
        check("shrink_idx", idx_out, 0);
        check("shrink_wrap", wrap, 0);
        mode = 2'b01;
        run(8);
        do_cfg(0, 0);
        run(6);
        check("len1_wrap", wrap, 1);
        check("len1_idx", idx_out, 0);

        // Write to the displayed entry and an out-of-range address.
        mode = 2'b00;
        run(2);
        wr_en = 1'b1; wr_addr = IDX_W'(m_idx); wr_data = 7'h40;
        cycle();
        wr_en = 1'b0;
        cycle();
        check("wr_disp_seg", seg_out, 7'h40);
        wr_en = 1'b1; wr_addr = 5'd20; wr_data = 7'h55;
        cycle();
        wr_en = 1'b0;
        mode = 2'b01;
        do_cfg(0, 40);
        run(20);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            reset    = ($urandom_range(0, 99) == 0);
            mode     = 2'($urandom);
            step     = 1'($urandom);
            step_dir = 1'($urandom);
            cfg_we   = ($urandom_range(0, 15) == 0);
            tick_div = DIV_W'($urandom_range(0, 4));
            msg_len  = (IDX_W+1)'($urandom_range(0, 40));
            wr_en    = 1'($urandom);
            wr_addr  = IDX_W'($urandom_range(0, 31));
            wr_data  = 7'($urandom);
            cycle();
        end
        idle();

        // Reset mid-scroll at idx 2, count 2.
        mode = 2'b01;
        do_cfg(3, 4);
        k = 0;
        while (!(m_idx == 2 && m_cnt == 2) && k < 40) begin
            cycle();
            k++;
        end
        check("pre_rst_idx", idx_out, 2);
        check("pre_rst_cnt", dbg_cnt, 2);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("mid_rst_idx", idx_out, 0);
        check("mid_rst_seg", seg_out, 0);
        check("mid_rst_cnt", dbg_cnt, 0);
        check("mid_rst_wrap", wrap, 0);
        run(20);
        check("def_div_cnt", dbg_cnt, 20);
        check("def_div_idx", idx_out, 0);
        run(1);
        check("def_div_step", idx_out, 1);
        do_cfg(0, 16);
        run(18);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg7_msg_scroller.md
Name: seg7_msg_scroller

Overview:
Parametrised 7-segment message scroller. It holds a run-time writable message buffer of MSG_LEN segment patterns and steps a display index through it. Stepping is driven by a programmable prescaler tick or by a manual step pulse, forward or reverse. It sits between the top-level IO wrapper and the 7-segment output pins, and exports the prescaler count for debug on the bidirectional pins.

Parameters:
DIV_W, 24, width of prescaler counter and tick_div input
MSG_LEN, 16, number of message buffer entries (2..256)
IDX_W, 4, index width; must satisfy 2**IDX_W >= MSG_LEN
DEF_DIV, 10_000_000, prescaler terminal value loaded at reset

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
mode  in  2  00 hold, 01 auto forward, 10 auto reverse, 11 manual step
step  in  1  single-cycle step request, used in manual mode only
step_dir  in  1  manual step direction: 0 forward, 1 reverse
cfg_we  in  1  load tick_div and msg_len this cycle
tick_div  in  DIV_W  prescaler terminal value
msg_len  in  IDX_W+1  active message length
wr_en  in  1  write message buffer entry
wr_addr  in  IDX_W  buffer write address
wr_data  in  7  segment pattern {g,f,e,d,c,b,a}
seg_out  out  7  registered segment pattern of current entry
idx_out  out  IDX_W  current display index
wrap  out  1  one-cycle pulse on index wrap-around
dbg_cnt  out  8  prescaler count bits [7:0]

Behaviour:
- Reset (synchronous, active-high; clock clk):
  - prescaler count = 0; div_reg = DEF_DIV; len_reg = MSG_LEN
  - idx = 0; seg_out = 0; wrap = 0; all buffer entries = 7'b0000000
- Prescaler:
  - count increments every cycle, independent of mode.
  - When count == div_reg: one-cycle internal tick, count <= 0 next cycle.
  - div_reg = 0 gives a tick every cycle.
- Config load (cfg_we = 1):
  - div_reg <= tick_div and count <= 0 in the same edge.
  - len_reg <= msg_len clamped to [1, MSG_LEN]; 0 becomes 1, values > MSG_LEN become MSG_LEN.
  - If current idx >= new length, idx <= 0 in the same edge; wrap not asserted.
  - A tick coinciding with cfg_we is discarded.
- Index advance events:
  - mode 01: on tick, forward.
  - mode 10: on tick, reverse.
  - mode 11: on step = 1, direction per step_dir; ticks ignored.
  - mode 00: no advance; step and ticks ignored.
  - Mode change takes effect on the next cycle's evaluation; the prescaler is not reset.
- Forward: idx == len_reg-1 -> 0 with wrap = 1, else idx+1.
- Reverse: idx == 0 -> len_reg-1 with wrap = 1, else idx-1.
- len_reg = 1: every advance keeps idx = 0 and pulses wrap.
- wrap is registered; high exactly the cycle after the advancing edge, coincident with the new idx_out.
- Buffer write:
  - wr_en writes wr_data to buffer[wr_addr].
  - wr_addr >= MSG_LEN: write ignored.
  - Writes are independent of mode and len_reg.
- Display:
  - seg_out <= buffer[idx] registered, so one cycle of latency after idx changes.
  - A write to the currently displayed entry appears on seg_out two edges after the write edge (write, then read register).
- Simultaneous cfg_we and advance: cfg_we wins; no advance that cycle.
- Reset asserted mid-operation overrides all other inputs on that edge.
- dbg_cnt = count[7:0], combinational from the register.

Test Plan:
- Reset, then write entries 0..3 = 7'h3E, 7'h77, 7'h7C, 7'h39; set msg_len = 4, tick_div = 3, mode 01.
  -> idx_out steps 0,1,2,3,0 every 4 cycles; wrap pulses on 3->0; seg_out follows 1 cycle after idx.
- Mode 10 with the same config from idx 0.
  -> idx 3,2,1,0,3 with wrap on 0->3; seg_out = 7'h39 one cycle after idx = 3.
- Mode 11: step pulses with step_dir 0,0,1; drive ticks with tick_div = 0.
  -> idx 1,2,1 only on step cycles; ticks cause no motion.
- At idx = 3, cfg_we with msg_len = 2.
  -> idx = 0, wrap = 0; thereafter idx toggles 0,1; msg_len = 0 behaves as length 1 with wrap every advance.
- Write 7'h40 to the entry currently displayed, and write to address 20 with MSG_LEN = 16.
  -> seg_out = 7'h40 two edges after the write; the out-of-range write leaves all entries unchanged.
- Assert reset mid-scroll at idx = 2 with count = 2.
  -> next cycle idx = 0, seg_out = 0, dbg_cnt = 0, wrap = 0, buffer cleared; div_reg = DEF_DIV.
